// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the per-core L1 ports, the memory arbiter and DataMemory.
// The arbiter takes the slave view; the cores and memory together form the master view.
interface dmem_arbiter_if #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32
) ();

  logic [NUM_CORES-1:0]        core_rd_en;
  logic [NUM_CORES-1:0]        core_wr_en;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES*3-1:0]      core_mask;
  logic [NUM_CORES-1:0]        core_ack;
  logic [DATA_W-1:0]           core_rdata;
  logic                        busy;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [2:0]                  mem_mask;
  logic                        mem_rd_en;
  logic                        mem_wr_en;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  core_rd_en, core_wr_en, core_addr, core_wdata, core_mask, mem_rdata,
    output core_ack, core_rdata, busy, mem_addr, mem_wdata, mem_mask, mem_rd_en, mem_wr_en
  );

  modport master (
    output core_rd_en, core_wr_en, core_addr, core_wdata, core_mask, mem_rdata,
    input  core_ack, core_rdata, busy, mem_addr, mem_wdata, mem_mask, mem_rd_en, mem_wr_en
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one DataMemory port among NUM_CORES L1 caches.
// One transaction in flight: IDLE picks a core, ACCESS holds the port, RESP acks.
module dmem_arbiter #(
  parameter int unsigned NUM_CORES   = 2,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned IdW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e               r_state;
  logic [IdW-1:0]       r_grant;
  logic [IdW-1:0]       r_rr_ptr;
  logic [CntW-1:0]      r_cnt;
  logic [NUM_CORES-1:0] r_ack;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_busy;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [2:0]           r_mem_mask;
  logic                 r_mem_rd_en;
  logic                 r_mem_wr_en;

  logic [NUM_CORES-1:0] w_req;
  logic                 w_found;
  logic [IdW-1:0]       w_pick;
  logic                 w_pick_wr;

  assign w_req     = bus.core_rd_en | bus.core_wr_en;
  assign w_pick_wr = bus.core_wr_en[w_pick];

  // First requester at or after r_rr_ptr, wrapping once.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!w_found && w_req[idx[IdW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[IdW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state     <= StAccess;
            r_grant     <= w_pick;
            r_cnt       <= CntW'(MEM_LATENCY - 1);
            r_busy      <= 1'b1;
            r_mem_addr  <= bus.core_addr[w_pick*ADDR_W +: ADDR_W];
            r_mem_wdata <= bus.core_wdata[w_pick*DATA_W +: DATA_W];
            r_mem_mask  <= bus.core_mask[w_pick*3 +: 3];
            // Write wins when a core raises both enables.
            r_mem_rd_en <= ~w_pick_wr;
            r_mem_wr_en <= w_pick_wr;
          end
        end
        StAccess: begin
          if (r_cnt == '0) begin
            if (r_mem_rd_en) r_rdata <= bus.mem_rdata;
            r_state     <= StResp;
            r_ack       <= NUM_CORES'(1) << r_grant;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StResp: begin
          r_state  <= StIdle;
          r_ack    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= (r_grant == IdW'(NUM_CORES - 1)) ? '0 : r_grant + IdW'(1);
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.core_ack   = r_ack;
  assign bus.core_rdata = r_rdata;
  assign bus.busy       = r_busy;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_mask   = r_mem_mask;
  assign bus.mem_rd_en  = r_mem_rd_en;
  assign bus.mem_wr_en  = r_mem_wr_en;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a MEM_LATENCY=1 instance checked through a scoreboard and
// a MEM_LATENCY=3 instance for latency and mid-transaction reset.
module tb_dmem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  dmem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  // Unwritten locations return a fixed pattern; 0x005 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_init(input logic [AW-1:0] a);
    return (a == 10'h005) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(a));
  endfunction

  logic [31:0]     mem1 [1024];
  logic [1023:0]   wval1;

  always @(posedge clk) if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  always @(posedge clk or negedge reset) begin
    if (!reset) wval1 <= '0;
    else if (bus1.mem_wr_en) wval1[bus1.mem_addr] <= 1'b1;
  end
  assign bus1.mem_rdata = !bus1.mem_rd_en ? 32'h0 :
                          wval1[bus1.mem_addr] ? mem1[bus1.mem_addr] : mem_init(bus1.mem_addr);
  assign bus3.mem_rdata = bus3.mem_rd_en ? mem_init(bus3.mem_addr) : 32'h0;

  typedef struct {
    int          core;
    bit          is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [int];
  logic [31:0] held;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          rd_cyc, wr_cyc, rd3_cyc, busy3_cyc, ack3_at;
  int          prev_core;
  bit          rr_mode;
  bit [N-1:0]  acked;
  bit          ack3_any;
  logic [N-1:0] ack3_vec;
  logic [31:0] rdata3;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
  endfunction

  // Advance to the next falling edge and monitor both instances there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acked = '0;
    if (bus1.mem_rd_en) rd_cyc++;
    if (bus1.mem_wr_en) wr_cyc++;
    if (|bus1.core_ack) begin
      check_eq("ack_onehot", $countones(bus1.core_ack), 1);
      for (int i = 0; i < N; i++) begin
        if (bus1.core_ack[i]) begin
          acked[i] = 1'b1;
          if (sb.size() == 0) begin
            check_eq("ack_unexpected", i, 99);
          end else begin
            e = sb.pop_front();
            check_eq("ack_core", i, e.core);
            if (e.is_rd) begin
              check_eq("rdata", bus1.core_rdata, e.rdata);
              held = e.rdata;
            end else begin
              check_eq("rdata_hold_on_wr", bus1.core_rdata, held);
            end
            if (rr_mode) check_eq("rr_no_repeat", (i == prev_core), 0);
            prev_core = i;
          end
          bus1.core_rd_en[i] = 1'b0;
          bus1.core_wr_en[i] = 1'b0;
        end
      end
    end
    if (bus3.mem_rd_en) rd3_cyc++;
    if (bus3.busy) busy3_cyc++;
    if (|bus3.core_ack) begin
      if (!ack3_any) begin
        ack3_at  = cyc;
        ack3_vec = bus3.core_ack;
        rdata3   = bus3.core_rdata;
      end
      ack3_any = 1'b1;
      bus3.core_rd_en = bus3.core_rd_en & ~bus3.core_ack;
      bus3.core_wr_en = bus3.core_wr_en & ~bus3.core_ack;
    end
  endtask

  task automatic issue1(input int core, input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [2:0] mask);
    exp_t e;
    bus1.core_rd_en[core]         = rd;
    bus1.core_wr_en[core]         = wr;
    bus1.core_addr[core*AW +: AW] = addr;
    bus1.core_wdata[core*DW +: DW] = wdata;
    bus1.core_mask[core*3 +: 3]   = mask;
    e.core  = core;
    e.is_rd = rd && !wr;
    e.rdata = e.is_rd ? ref_rd(addr) : 32'h0;
    if (wr) ref_mem[int'(addr)] = wdata;
    sb.push_back(e);
  endtask

  task automatic issue3(input int core, input logic [AW-1:0] addr);
    bus3.core_rd_en[core]         = 1'b1;
    bus3.core_addr[core*AW +: AW] = addr;
    bus3.core_mask[core*3 +: 3]   = 3'b111;
  endtask

  task automatic wait_ack1(input int core, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      got = acked[core];
    end
    check_eq($sformatf("ack_wait_c%0d", core), got, 1);
  endtask

  task automatic wait_any1(input int budget, output int who);
    who = -1;
    for (int k = 0; k < budget && who < 0; k++) begin
      tick();
      if (acked[0]) who = 0;
      else if (acked[1]) who = 1;
    end
    check_eq("ack_wait_any", (who >= 0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check_eq("rst1_ctrl", {bus1.core_ack, bus1.busy, bus1.mem_rd_en, bus1.mem_wr_en,
                           bus1.mem_mask, bus1.mem_addr}, 0);
    check_eq("rst1_data", {bus1.core_rdata, bus1.mem_wdata}, 0);
    check_eq("rst3_ctrl", {bus3.core_ack, bus3.busy, bus3.mem_rd_en, bus3.mem_wr_en,
                           bus3.mem_mask, bus3.mem_addr}, 0);
    check_eq("rst3_data", {bus3.core_rdata, bus3.mem_wdata}, 0);
    sb.delete();
    ref_mem.delete();
    held      = '0;
    rr_mode   = 1'b0;
    prev_core = -1;
    reset     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int who;
    int c0;
    bus1.core_rd_en = '0; bus1.core_wr_en = '0; bus1.core_addr = '0;
    bus1.core_wdata = '0; bus1.core_mask  = '0;
    bus3.core_rd_en = '0; bus3.core_wr_en = '0; bus3.core_addr = '0;
    bus3.core_wdata = '0; bus3.core_mask  = '0;
    do_reset();

    // Single read, latency 1: one access cycle, ack the next.
    issue1(0, 1'b1, 1'b0, 10'h005, 32'h0, 3'b010);
    tick();
    check_eq("sr_rd_en", bus1.mem_rd_en, 1);
    check_eq("sr_addr", bus1.mem_addr, 10'h005);
    check_eq("sr_mask", bus1.mem_mask, 3'b010);
    check_eq("sr_busy", bus1.busy, 1);
    check_eq("sr_no_ack_yet", bus1.core_ack, 2'b00);
    tick();
    check_eq("sr_rd_en_off", bus1.mem_rd_en, 0);
    check_eq("sr_ack", bus1.core_ack, 2'b01);
    check_eq("sr_rdata", bus1.core_rdata, 32'hDEADBEEF);
    tick();
    check_eq("sr_ack_pulse", bus1.core_ack, 2'b00);
    check_eq("sr_busy_off", bus1.busy, 0);

    // Simultaneous requests right after reset: core0 first.
    do_reset();
    wr_cyc = 0;
    issue1(0, 1'b0, 1'b1, 10'h010, 32'h11111111, 3'b111);
    issue1(1, 1'b1, 1'b0, 10'h010, 32'h0, 3'b111);
    wait_ack1(0, 10);
    wait_ack1(1, 10);
    check_eq("sim_wr_once", wr_cyc, 1);

    // Round-robin with both cores requesting continuously.
    rr_mode   = 1'b1;
    prev_core = -1;
    issue1(0, 1'b1, 1'b0, 10'h040, 32'h0, 3'b111);
    issue1(1, 1'b1, 1'b0, 10'h041, 32'h0, 3'b111);
    for (int t = 0; t < 4; t++) begin
      wait_any1(10, who);
      if (t < 2 && who >= 0) issue1(who, 1'b1, 1'b0, AW'(32'h50 + t * 2 + who), 32'h0, 3'b111);
    end
    rr_mode = 1'b0;

    // rd+wr together: only the write reaches memory.
    rd_cyc = 0;
    wr_cyc = 0;
    issue1(1, 1'b1, 1'b1, 10'h020, 32'hA5A5A5A5, 3'b111);
    wait_ack1(1, 10);
    check_eq("conf_no_rd", rd_cyc, 0);
    check_eq("conf_one_wr", wr_cyc, 1);
    issue1(0, 1'b1, 1'b0, 10'h020, 32'h0, 3'b111);
    wait_ack1(0, 10);
    check_eq("sb_drained", sb.size(), 0);

    // Latency 3 read.
    rd3_cyc   = 0;
    busy3_cyc = 0;
    ack3_any  = 1'b0;
    c0        = cyc;
    issue3(0, 10'h007);
    repeat (8) tick();
    check_eq("lat3_rd_cycles", rd3_cyc, 3);
    check_eq("lat3_busy_cycles", busy3_cyc, 4);
    check_eq("lat3_ack_seen", ack3_any, 1);
    check_eq("lat3_ack_delay", ack3_at - c0, 4);
    check_eq("lat3_ack_vec", ack3_vec, 2'b01);
    check_eq("lat3_rdata", rdata3, mem_init(10'h007));

    // Reset during the second access cycle of a core1 read.
    issue3(1, 10'h009);
    tick();
    tick();
    check_eq("rst_mid_pre_rd", bus3.mem_rd_en, 1);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_rd_drop", bus3.mem_rd_en, 0);
    check_eq("rst_mid_busy_drop", bus3.busy, 0);
    ack3_any = 1'b0;
    tick();
    tick();
    check_eq("rst_mid_no_ack", ack3_any, 0);
    reset = 1'b1;
    issue3(0, 10'h003);
    for (int k = 0; k < 12 && !ack3_any; k++) tick();
    check_eq("rst_post_ack_seen", ack3_any, 1);
    check_eq("rst_post_grant_c0", ack3_vec, 2'b01);
    check_eq("rst_post_rdata", rdata3, mem_init(10'h003));
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
